// File: rtl/stack_ctrl_if.sv
// Command and RAM bus bundle for stack_ctrl: the panel/RAM side uses master,
// the controller uses slave.
interface stack_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          push;
  logic          pop;
  logic          clear;
  logic [DW-1:0] din;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW-1:0] top;
  logic          empty;
  logic          full;
  logic          busy;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          err;

  modport master (
    output push, pop, clear, din, ram_rdata,
    input  ram_addr, ram_we, ram_wdata, top, empty, full, busy,
           dout, dout_valid, err
  );

  modport slave (
    input  push, pop, clear, din, ram_rdata,
    output ram_addr, ram_we, ram_wdata, top, empty, full, busy,
           dout, dout_valid, err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Push/pop/clear sequencer for a single-port synchronous-read stack RAM.
// Optional sticky error flag enabled by defining STACK_ERR_EN.
module stack_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst,
  stack_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPT} state_t;

  localparam logic [AW-1:0] TOP_MAX = {AW{1'b1}};

  state_t        state, state_nxt;
  logic [AW-1:0] top_r, top_nxt;
  logic [DW-1:0] wdata_r, wdata_nxt;
  logic [DW-1:0] dout_r, dout_nxt;
  logic          dvld_r, dvld_nxt;
  logic          full_c, empty_c;

  assign full_c  = (top_r == TOP_MAX);
  assign empty_c = (top_r == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      top_r   <= '0;
      wdata_r <= '0;
      dout_r  <= '0;
      dvld_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      top_r   <= top_nxt;
      wdata_r <= wdata_nxt;
      dout_r  <= dout_nxt;
      dvld_r  <= dvld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    top_nxt   = top_r;
    wdata_nxt = wdata_r;
    dout_nxt  = dout_r;
    dvld_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          top_nxt = '0;
        end else if (bus.push && !bus.pop) begin
          if (!full_c) begin
            wdata_nxt = bus.din;
            state_nxt = WRITE;
          end
        end else if (bus.pop && !bus.push) begin
          // Pre-decrement so READ addresses the entry being removed
          if (!empty_c) begin
            top_nxt   = top_r - 1'b1;
            state_nxt = READ;
          end
        end
      end
      WRITE: begin
        top_nxt   = top_r + 1'b1;
        state_nxt = IDLE;
      end
      READ: begin
        state_nxt = CAPT;
      end
      CAPT: begin
        dout_nxt  = bus.ram_rdata;
        dvld_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ram_addr   = top_r;
  assign bus.ram_we     = (state == WRITE);
  assign bus.ram_wdata  = wdata_r;
  assign bus.top        = top_r;
  assign bus.empty      = empty_c;
  assign bus.full       = full_c;
  assign bus.busy       = (state != IDLE);
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dvld_r;

`ifdef STACK_ERR_EN
  logic err_r, err_nxt, err_evt, clear_acc;

  always_comb begin
    clear_acc = (state == IDLE) && bus.clear;
    if (state != IDLE) begin
      err_evt = bus.push || bus.pop || bus.clear;
    end else begin
      err_evt = !bus.clear && ((bus.push && bus.pop) ||
                               (bus.push && full_c) ||
                               (bus.pop && empty_c));
    end
    // An accepted clear wins over any error raised in the same cycle
    err_nxt = clear_acc ? 1'b0 : (err_r || err_evt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_r <= 1'b0;
    else     err_r <= err_nxt;
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a queue-based stack model predicts RAM
// writes, popped values and status; a negedge monitor compares.
module tb_stack_ctrl;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int CAP = (1 << AW) - 1;
`ifdef STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  stack_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] mem [0:CAP];
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;

  int            mtop;
  int            mbusy;
  bit            mode_pop;
  bit            m_err;
  bit            m_dv;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_pend;
  logic [DW-1:0] stk[$];
  logic [DW-1:0] rq[$];
  int            wq_addr[$];
  logic [DW-1:0] wq_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mtop = 0; mbusy = 0; mode_pop = 1'b0; m_err = 1'b0; m_dv = 1'b0;
    m_dout = '0; m_pend = '0;
    stk.delete(); rq.delete(); wq_addr.delete(); wq_data.delete();
  endtask

  // Applies the stack rules for one clock edge with the given command inputs
  task automatic model_tick(input bit p, input bit o, input bit c, input logic [DW-1:0] d);
    m_dv = 1'b0;
    if (mbusy > 0) begin
      if (p || o || c) m_err = 1'b1;
      if (!mode_pop) mtop++;
      else if (mbusy == 1) begin
        m_dv = 1'b1;
        m_dout = m_pend;
      end
      mbusy--;
    end else if (c) begin
      mtop = 0; stk.delete(); m_err = 1'b0;
    end else if (p && o) begin
      m_err = 1'b1;
    end else if (p) begin
      if (mtop == CAP) m_err = 1'b1;
      else begin
        wq_addr.push_back(mtop); wq_data.push_back(d); stk.push_back(d);
        mbusy = 1; mode_pop = 1'b0;
      end
    end else if (o) begin
      if (mtop == 0) m_err = 1'b1;
      else begin
        m_pend = stk.pop_back(); rq.push_back(m_pend);
        mtop--; mbusy = 2; mode_pop = 1'b1;
      end
    end
  endtask

  task automatic step(input bit p, input bit o, input bit c, input logic [DW-1:0] d);
    bus.push = p; bus.pop = o; bus.clear = c; bus.din = d;
    @(posedge clk);
    model_tick(p, o, c, d);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.din = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  always @(negedge clk) begin
    chk("top", 32'(bus.top), 32'(mtop));
    chk("empty", 32'(bus.empty), 32'(mtop == 0));
    chk("full", 32'(bus.full), 32'(mtop == CAP));
    chk("busy", 32'(bus.busy), 32'(mbusy > 0));
    chk("ram_we", 32'(bus.ram_we), 32'(mbusy > 0 && !mode_pop));
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    chk("err", 32'(bus.err), 32'(ERR_EN & m_err));
    chk("dout", 32'(bus.dout), 32'(m_dout));
    if (bus.ram_we === 1'b1) begin
      total++;
      if (wq_addr.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: addr %0h data %0h with no write expected", bus.ram_addr, bus.ram_wdata);
      end else begin
        total--;
        chk("wr_addr", 32'(bus.ram_addr), 32'(wq_addr.pop_front()));
        chk("wr_data", 32'(bus.ram_wdata), 32'(wq_data.pop_front()));
      end
    end
    if (bus.dout_valid === 1'b1) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: dout %0h with no pop expected", bus.dout);
      end else begin
        total--;
        chk("pop_data", 32'(bus.dout), 32'(rq.pop_front()));
      end
    end
  end

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.din = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // First push lands at address 0
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    idle(2);

    // LIFO order
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, 8'h11); idle(1);
    step(1'b1, 1'b0, 1'b0, 8'h22); idle(1);
    step(1'b0, 1'b1, 1'b0, '0); idle(3);
    step(1'b0, 1'b1, 1'b0, '0); idle(3);

    // Pop on empty
    step(1'b0, 1'b1, 1'b0, '0); idle(3);
    step(1'b0, 1'b0, 1'b1, '0); idle(1);

    // Fill to capacity, then one push too many
    for (int i = 0; i < CAP; i++) begin
      step(1'b1, 1'b0, 1'b0, DW'(i * 7 + 3));
      idle(1);
    end
    step(1'b1, 1'b0, 1'b0, 8'hEE); idle(3);
    step(1'b0, 1'b1, 1'b0, '0); idle(3);
    step(1'b0, 1'b0, 1'b1, '0); idle(1);

    // Push during WRITE is dropped; push+pop is a no-op; clear+push clears
    step(1'b1, 1'b0, 1'b0, 8'h31);
    step(1'b1, 1'b0, 1'b0, 8'h32); idle(2);
    step(1'b1, 1'b1, 1'b0, 8'h33); idle(2);
    step(1'b1, 1'b0, 1'b1, 8'h34); idle(2);

    // Reset in the READ cycle of a pop from top=3
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
      idle(1);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_top", 32'(bus.top), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_dv", 32'(bus.dout_valid), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // Randomized command mix
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 2, DW'($urandom));
    end
    idle(5);

    chk("wq_drained", 32'(wq_addr.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencing controller for the single-port stack RAM behind the push/pop/clear front panel. It accepts single-cycle command pulses and maintains the stack pointer and empty/full status. It drives the RAM address, write-enable and write data, and captures popped data into a held output register. It sits between the button single-pulsers/switch debouncers and the RAM, and feeds `top` and `dout` to the seven-segment display.

## Interface
Parameters:
- `AW`, 8: RAM address width; capacity is 2^AW − 1 entries.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `push`  in  1  single-cycle push request.
- `pop`  in  1  single-cycle pop request.
- `clear`  in  1  single-cycle clear request.
- `din`  in  DW  data to push; sampled in the cycle `push` is accepted.
- `ram_addr`  out  AW  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM read data; synchronous read, valid one cycle after the address is presented.
- `top`  out  AW  current entry count.
- `empty`  out  1  `top == 0`.
- `full`  out  1  `top == 2^AW − 1`.
- `busy`  out  1  FSM is not in IDLE.
- `dout`  out  DW  last popped value, held.
- `dout_valid`  out  1  one-cycle pulse when `dout` updates.
- `err`  out  1  sticky error flag (see Configuration).

## Operation
- States: IDLE, WRITE, READ, CAPT. Encoding is free.
- `ram_we` is 1 only in WRITE. It is decoded from the state register, never from the inputs.
- Commands are evaluated only in IDLE:
  - `clear` has top priority: `top` ← 0, remain in IDLE. `dout` is unchanged.
  - `push` and `pop` both high without `clear`: no-op.
  - `push` alone, not full: latch `din` into `ram_wdata`, go to WRITE.
  - `push` when full: no-op.
  - `pop` alone, not empty: `top` ← `top` − 1, go to READ.
  - `pop` when empty: no-op.
- WRITE: `ram_addr` = `top`, `ram_we` = 1. On exit `top` ← `top` + 1, go to IDLE.
- READ: `ram_addr` = `top` (already decremented), go to CAPT.
- CAPT: `dout` ← `ram_rdata`, then go to IDLE.
- Any command arriving while `busy` is dropped. It is not queued.
- `top` never wraps. The full/empty guards make increment-past-max and decrement-below-zero impossible.
- Reset values: state IDLE, `top` 0, `empty` 1, `full` 0, `busy` 0, `ram_we` 0, `ram_addr` 0, `ram_wdata` 0, `dout` 0, `dout_valid` 0, `err` 0.
- Reset asserted mid-operation aborts immediately: `ram_we` drops asynchronously and no partial pointer update survives.

## Timing
Push accepted at edge N:
- Cycle N+1 is WRITE, with `ram_we` = 1.
- `top` shows the new value from N+2.
- IDLE and ready again from N+2.
- Throughput is 1 push per 2 cycles.

Pop accepted at edge N:
- `top` is decremented from N+1.
- Cycle N+1 is READ, cycle N+2 is CAPT.
- `dout` is updated and `dout_valid` = 1 in cycle N+3 only.
- IDLE and ready again from N+3.

Clear accepted at edge N:
- `top` = 0 from N+1.
- No `busy` cycle.

`empty` and `full` are combinational from `top`.

## Configuration
Macro: `STACK_ERR_EN`.
- Defined: `err` is set at the next edge and stays set on any of:
  - push while full;
  - pop while empty;
  - push and pop simultaneous;
  - any command while `busy`.
- When defined, `err` is cleared only by `rst` or an accepted `clear`. An accepted `clear` that coincides with an error event leaves `err` at 0.
- Not defined: `err` is tied to 0 and no error logic is synthesized. The port remains present.

## Test plan
- Reset, then push `din` = 8'hA5 → RAM write at addr 0 with data A5 in cycle N+1; `top` = 1, `empty` = 0 at N+2.
- Push 8'h11, then 8'h22, then pop twice → `dout` = 22 with `dout_valid` pulse, then `dout` = 11; `top` = 0, `empty` = 1.
- Pop on empty stack → `top` stays 0, no RAM access, `dout_valid` stays 0; `err` = 1 when `STACK_ERR_EN` is defined, 0 otherwise.
- Push 255 times (AW = 8) → `full` = 1, `top` = 255; a 256th push causes no `ram_we` and `top` stays 255.
- Push pulse during WRITE of a previous push → dropped; `top` advances by only 1; `err` = 1 when `STACK_ERR_EN` is defined. Push and pop in the same IDLE cycle → no-op; `err` = 1 when `STACK_ERR_EN` is defined. `clear` together with push → `top` = 0 and `err` = 0.
- Assert `rst` during READ after a pop from `top` = 3 → all outputs return to reset values immediately and `dout_valid` never pulses.
